// File: rtl/mem_port_arbiter_4_pkg.sv
// Shared types and constants for the four-requester memory port arbiter.
// Requester indices are fixed by pipeline wiring: fetch, load/store, mul/div spill, debug.
package mem_port_arbiter_4_pkg;

  localparam int NREQ  = 4;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic [1:0] REQ_IF  = 2'd0;
  localparam logic [1:0] REQ_LSU = 2'd1;
  localparam logic [1:0] REQ_MDU = 2'd2;
  localparam logic [1:0] REQ_DBG = 2'd3;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_4_if.sv
// Requester/memory handshake bundle between the pipeline, the arbiter and the memory controller.
// master is the arbiter side; slave is whoever drives requests and memory completion.
interface mem_port_arbiter_4_if;
  import mem_port_arbiter_4_pkg::*;

  logic [NREQ-1:0] req;
  logic            mem_done;
  logic [1:0]      select;
  logic [NREQ-1:0] grant;
  logic            mem_req;
  logic [NREQ-1:0] ack;
  logic            err;

  modport master (
    input  req, mem_done,
    output select, grant, mem_req, ack, err
  );

  modport slave (
    output req, mem_done,
    input  select, grant, mem_req, ack, err
  );

endinterface

// File: rtl/mem_port_arbiter_4_rr_pick_4.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping 3->0.
module rr_pick_4
  import mem_port_arbiter_4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      winner,
  output logic            valid
);

  logic [1:0] idx;

  always_comb begin
    winner = ptr;
    valid  = 1'b0;
    idx    = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + 2'(i);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter_4.sv
// Round-robin owner of the shared 32-bit memory port; drives the address/data mux select.
//   state   | meaning
//   IDLE    | no owner; pick a winner from req starting at ptr
//   BUSY    | owner holds the port, mem_req high, waiting for mem_done or timeout
//   RELEASE | one turnaround cycle so the acknowledged requester can drop req
module mem_port_arbiter_4
  import mem_port_arbiter_4_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_4_if.master bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e state, state_nxt;

  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       select_q, select_nxt;
  logic [NREQ-1:0]  grant_q, grant_nxt;
  logic [NREQ-1:0]  ack_q, ack_nxt;
  logic             mem_req_q, mem_req_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [1:0] winner;
  logic       win_valid;
  logic       done_hit;
  logic       tmo_hit;

  rr_pick_4 u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  // A completion on the timeout cycle wins over the timeout.
  assign done_hit = (state == BUSY) && bus.mem_done;
  assign tmo_hit  = (state == BUSY) && !bus.mem_done && (cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      select_q  <= 2'd0;
      grant_q   <= '0;
      ack_q     <= '0;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      select_q  <= select_nxt;
      grant_q   <= grant_nxt;
      ack_q     <= ack_nxt;
      mem_req_q <= mem_req_nxt;
      err_q     <= err_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = BUSY;
      BUSY:    if (done_hit || tmo_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ptr_nxt     = ptr;
    select_nxt  = select_q;
    grant_nxt   = grant_q;
    ack_nxt     = '0;
    mem_req_nxt = 1'b0;
    err_nxt     = 1'b0;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (win_valid) begin
          select_nxt  = winner;
          grant_nxt   = onehot4(winner);
          mem_req_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (done_hit || tmo_hit) begin
          grant_nxt = '0;
          ack_nxt   = grant_q;
          err_nxt   = tmo_hit;
          ptr_nxt   = select_q + 2'd1;
          cnt_nxt   = '0;
        end else begin
          mem_req_nxt = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
      default: begin
        grant_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.select  = select_q;
  assign bus.grant   = grant_q;
  assign bus.mem_req = mem_req_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter_4.sv
// Scoreboard bench: stimulus pushes predicted owner/outcome/latency, a negedge monitor checks them.
module tb_mem_port_arbiter_4;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_4_if bus ();

  mem_port_arbiter_4 #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   w;
    int   lat;
    logic err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_served;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: most recently served requester has lowest priority.
  function automatic int model_pick(input logic [3:0] pat);
    for (int i = 1; i <= 4; i++) begin
      if (pat[(last_served + i) % 4]) return (last_served + i) % 4;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  bit         in_txn     = 0;
  bit         prev_reset = 0;
  bit         post_ack   = 0;
  logic [3:0] prev_grant = '0;
  int         mon_w      = 0;
  int         mon_cyc    = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (reset) begin
      in_txn     = 0;
      prev_reset = 1;
      post_ack   = 0;
      prev_grant = '0;
    end else begin
      if (prev_reset) begin
        chk("rst_grant",   32'(bus.grant),   0);
        chk("rst_select",  32'(bus.select),  0);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_ack",     32'(bus.ack),     0);
        chk("rst_err",     32'(bus.err),     0);
        prev_reset = 0;
      end
      if (post_ack) begin
        chk("release_turnaround_grant", 32'(bus.grant), 0);
        chk("ack_width", 32'(bus.ack), 0);
        chk("err_width", 32'(bus.err), 0);
        post_ack = 0;
      end else if (bus.grant != 0 && prev_grant == 0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_grant", 32'(bus.grant), 0);
        end else begin
          mon_w = exp_q[0].w;
          chk("grant",   32'(bus.grant),   32'(1) << mon_w);
          chk("select",  32'(bus.select),  32'(mon_w));
          chk("mem_req", 32'(bus.mem_req), 1);
          in_txn  = 1;
          mon_cyc = 0;
        end
      end else if (in_txn) begin
        mon_cyc++;
        if (bus.ack != 0) begin
          mon_e = exp_q.pop_front();
          chk("ack",            32'(bus.ack),     32'(1) << mon_e.w);
          chk("err",            32'(bus.err),     32'(mon_e.err));
          chk("latency",        32'(mon_cyc),     32'(mon_e.lat));
          chk("release_grant",  32'(bus.grant),   0);
          chk("release_memreq", 32'(bus.mem_req), 0);
          chk("release_select", 32'(bus.select),  32'(mon_e.w));
          in_txn   = 0;
          post_ack = 1;
        end else begin
          chk("busy_grant",   32'(bus.grant),   32'(1) << mon_w);
          chk("busy_mem_req", 32'(bus.mem_req), 1);
          chk("busy_err",     32'(bus.err),     0);
          if (mon_cyc > TMO) chk("busy_overrun", 32'(mon_cyc), 32'(TMO));
        end
      end else begin
        chk("idle_ack",     32'(bus.ack),     0);
        chk("idle_err",     32'(bus.err),     0);
        chk("idle_mem_req", 32'(bus.mem_req), 0);
      end
      prev_grant = bus.grant;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      bus.mem_done = 1'b0;
      if (bus.grant != 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("grant_wait_timeout", 0, 1);
  endtask

  // j: BUSY cycle index on which mem_done is driven (>= TMO means never).
  task automatic txn(input logic [3:0] pat, input int j, input bit wig, input bit spur);
    exp_t e;
    bit   ok;
    bit   got;
    e.w   = model_pick(pat);
    e.lat = ((j < TMO) ? j : TMO - 1) + 1;
    e.err = (j >= TMO);
    exp_q.push_back(e);
    bus.req = pat;
    wait_grant(ok);
    if (!ok) return;
    last_served = e.w;
    got = 0;
    for (int c = 0; c < TMO + 4; c++) begin
      bus.mem_done = (c == j);
      if (wig) bus.req = 4'($urandom);
      @(posedge clk); #1;
      if (bus.ack != 0) begin
        got = 1;
        break;
      end
    end
    bus.mem_done = spur;
    bus.req      = pat & ~(4'b0001 << e.w);
    if (!got) chk("ack_wait_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit spur);
    bus.req = '0;
    for (int i = 0; i < n; i++) begin
      bus.mem_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    bus.mem_done = 1'b0;
  endtask

  task automatic reset_mid_busy(input logic [3:0] pat);
    exp_t e;
    bit   ok;
    e.w   = model_pick(pat);
    e.lat = TMO;
    e.err = 1'b0;
    exp_q.push_back(e);
    bus.req = pat;
    wait_grant(ok);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset       = 1'b0;
    bus.req     = '0;
    last_served = 3;
  endtask

  initial begin
    logic [3:0] pat;
    reset        = 1'b1;
    bus.req      = '0;
    bus.mem_done = 1'b0;
    last_served  = 3;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    txn(4'b0100, 3, 0, 0);
    idle(2, 0);
    repeat (5) txn(4'b1111, 1, 0, 0);
    txn(4'b1000, 0, 0, 0);
    txn(4'b1001, 1, 0, 0);
    idle(1, 0);
    txn(4'b0010, 99, 0, 0);
    idle(2, 0);
    txn(4'b0010, TMO - 1, 0, 1);
    idle(4, 1);
    txn(4'b0010, 0, 0, 0);
    reset_mid_busy(4'b1100);
    idle(1, 0);
    txn(4'b1111, 1, 0, 0);

    repeat (200) begin
      pat = 4'($urandom);
      if (pat == 0) idle($urandom_range(1, 3), 1);
      else txn(pat, $urandom_range(0, TMO + 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(4, 0);
    chk("queue_drain", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
